rgb_to_hsv: RTL and testbench

Converts one 8-bit-per-channel RGB pixel into the HSV triple used by `hsv_to_rgb`: Hue 0..359 degrees, Saturation 0..100, Value 0..100. It sits upstream of `hsv_to_rgb` in the colour path, so colours captured in RGB can be edited in HSV and sent back. It uses one shared 16-bit/8-bit restoring divider for all three quotients. The latency is fixed and there are valid/ready handshakes on both sides.

---
 rtl/rgb_to_hsv_if.sv | 24 ++
 rtl/rgb_to_hsv.sv | 206 ++++++++++++++++++++
 tb/tb_rgb_to_hsv.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_to_hsv_if.sv
// Pixel-in / HSV-out handshake bundle for rgb_to_hsv.
// The master side drives pixels and takes results; the slave side is the converter.
interface rgb_to_hsv_if;
    logic [7:0] R;
    logic [7:0] G;
    logic [7:0] B;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] Hue;
    logic [8:0] Saturation;
    logic [8:0] Value;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output R, G, B, in_valid, out_ready,
        input  in_ready, Hue, Saturation, Value, out_valid
    );

    modport slave (
        input  R, G, B, in_valid, out_ready,
        output in_ready, Hue, Saturation, Value, out_valid
    );
endinterface

// File: rtl/rgb_to_hsv.sv
// RGB888 to HSV (H 0..359, S/V 0..100) converter with a fixed 50-cycle latency.
// One shared restoring divider is reused for V, S and the hue offset in turn.
module rgb_to_hsv (
    input  logic        clk,
    input  logic        reset,
    rgb_to_hsv_if.slave px
);

    typedef enum logic [2:0] {
        IDLE, PREP, DIV_V, DIV_S, DIV_H, FINISH, DONE
    } state_t;

    state_t      state, state_nxt;

    logic [7:0]  r_q, g_q, b_q;
    logic [7:0]  max_q, delta_q, dabs_q;
    logic        dneg_q;
    logic [1:0]  maxsel_q;

    logic [15:0] dq;
    logic [7:0]  rem;
    logic [7:0]  divisor;
    logic [3:0]  cnt;

    logic [6:0]  v_q, s_q;
    logic [5:0]  h_q;
    logic [8:0]  hue_r, sat_r, val_r;

    logic [7:0]  max_c, min_c, dabs_c;
    logic [1:0]  maxsel_c;
    logic [8:0]  d_c;

    logic [8:0]  rem_sh;
    logic        ge;
    logic [7:0]  rem_nxt;
    logic [15:0] quo_nxt;

    logic [15:0] dvd_v, dvd_s, dvd_h;
    logic [8:0]  base;
    logic [9:0]  hue_sum;
    logic [8:0]  hue_c;

    // Max-channel pick uses strict compares so ties fall to R, then G.
    always_comb begin
        max_c    = r_q;
        maxsel_c = 2'd0;
        if (g_q > max_c) begin
            max_c    = g_q;
            maxsel_c = 2'd1;
        end
        if (b_q > max_c) begin
            max_c    = b_q;
            maxsel_c = 2'd2;
        end
        min_c = r_q;
        if (g_q < min_c) min_c = g_q;
        if (b_q < min_c) min_c = b_q;
        case (maxsel_c)
            2'd0:    d_c = {1'b0, g_q} - {1'b0, b_q};
            2'd1:    d_c = {1'b0, b_q} - {1'b0, r_q};
            default: d_c = {1'b0, r_q} - {1'b0, g_q};
        endcase
        dabs_c = d_c[8] ? (~d_c[7:0] + 8'd1) : d_c[7:0];
    end

    // One restoring step: a shifted-out carry always means the divisor fits.
    always_comb begin
        rem_sh  = {rem, dq[15]};
        ge      = rem_sh[8] | (rem_sh[7:0] >= divisor);
        rem_nxt = ge ? (rem_sh[7:0] - divisor) : rem_sh[7:0];
        quo_nxt = {dq[14:0], ge};
    end

    always_comb begin
        dvd_v = {8'd0, max_c}   * 16'd100;
        dvd_s = {8'd0, delta_q} * 16'd100;
        dvd_h = {8'd0, dabs_q}  * 16'd60;
    end

    // Negative offsets are folded in as +360 and the sum wrapped once.
    always_comb begin
        case (maxsel_q)
            2'd0:    base = 9'd0;
            2'd1:    base = 9'd120;
            default: base = 9'd240;
        endcase
        if (dneg_q)
            hue_sum = {1'b0, base} + 10'd360 - {4'd0, h_q};
        else
            hue_sum = {1'b0, base} + {4'd0, h_q};
        if (delta_q == 8'd0)
            hue_c = 9'd0;
        else if (hue_sum >= 10'd360)
            hue_c = 9'(hue_sum - 10'd360);
        else
            hue_c = hue_sum[8:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (px.in_valid) state_nxt = PREP;
            PREP:    state_nxt = DIV_V;
            DIV_V:   if (cnt == 4'd15) state_nxt = DIV_S;
            DIV_S:   if (cnt == 4'd15) state_nxt = DIV_H;
            DIV_H:   if (cnt == 4'd15) state_nxt = FINISH;
            FINISH:  state_nxt = DONE;
            DONE:    if (px.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Each divide phase reloads the divider on its last step so the next starts clean.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q      <= 8'd0;
            g_q      <= 8'd0;
            b_q      <= 8'd0;
            max_q    <= 8'd0;
            delta_q  <= 8'd0;
            dabs_q   <= 8'd0;
            dneg_q   <= 1'b0;
            maxsel_q <= 2'd0;
            dq       <= 16'd0;
            rem      <= 8'd0;
            divisor  <= 8'd1;
            cnt      <= 4'd0;
            v_q      <= 7'd0;
            s_q      <= 7'd0;
            h_q      <= 6'd0;
            hue_r    <= 9'd0;
            sat_r    <= 9'd0;
            val_r    <= 9'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (px.in_valid) begin
                        r_q <= px.R;
                        g_q <= px.G;
                        b_q <= px.B;
                    end
                end
                PREP: begin
                    max_q    <= max_c;
                    delta_q  <= max_c - min_c;
                    dabs_q   <= dabs_c;
                    dneg_q   <= d_c[8];
                    maxsel_q <= maxsel_c;
                    dq       <= dvd_v;
                    divisor  <= 8'd255;
                    rem      <= 8'd0;
                    cnt      <= 4'd0;
                end
                DIV_V: begin
                    dq  <= quo_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        v_q     <= quo_nxt[6:0];
                        dq      <= dvd_s;
                        divisor <= (max_q == 8'd0) ? 8'd1 : max_q;
                        rem     <= 8'd0;
                    end
                end
                DIV_S: begin
                    dq  <= quo_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        s_q     <= (max_q == 8'd0) ? 7'd0 : quo_nxt[6:0];
                        dq      <= dvd_h;
                        divisor <= (delta_q == 8'd0) ? 8'd1 : delta_q;
                        rem     <= 8'd0;
                    end
                end
                DIV_H: begin
                    dq  <= quo_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15)
                        h_q <= (delta_q == 8'd0) ? 6'd0 : quo_nxt[5:0];
                end
                FINISH: begin
                    hue_r <= hue_c;
                    sat_r <= {2'b00, s_q};
                    val_r <= {2'b00, v_q};
                end
                default: ;
            endcase
        end
    end

    assign px.in_ready   = (state == IDLE);
    assign px.out_valid  = (state == DONE);
    assign px.Hue        = hue_r;
    assign px.Saturation = sat_r;
    assign px.Value      = val_r;

endmodule

// File: tb/tb_rgb_to_hsv.sv
// Randomised scoreboard bench for rgb_to_hsv: accepted pixels push a modelled HSV
// result; a negedge monitor checks latency, hold behaviour and values on each result.
module tb_rgb_to_hsv;

    typedef struct {
        int h;
        int s;
        int v;
        int acc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sbq[$];
    bit   seen_valid = 0;
    bit   chk_idle = 0;
    int   rdy_mode = 0;
    int   hold_cnt = 0;

    rgb_to_hsv_if px();

    rgb_to_hsv dut (
        .clk   (clk),
        .reset (reset),
        .px    (px)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input int r, input int g, input int b);
        exp_t e;
        int mx, mn, dl, d, base, q, h;
        if (r >= g && r >= b) begin
            mx = r; base = 0; d = g - b;
        end else if (g >= b) begin
            mx = g; base = 120; d = b - r;
        end else begin
            mx = b; base = 240; d = r - g;
        end
        mn = (r < g) ? r : g;
        mn = (b < mn) ? b : mn;
        dl = mx - mn;
        e.v = (mx * 100) / 255;
        e.s = (mx == 0) ? 0 : (dl * 100) / mx;
        if (dl == 0) begin
            h = 0;
        end else begin
            q = (60 * ((d < 0) ? -d : d)) / dl;
            h = (d >= 0) ? base + q : base - q;
            if (h < 0) h = h + 360;
            if (h == 360) h = 0;
        end
        e.h = h;
        e.acc = 0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Downstream ready generator: tied high, random, or a 20-cycle stall per result.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: px.out_ready = 1'b1;
            1: px.out_ready = 1'($urandom_range(0, 1));
            default: begin
                if (px.out_valid && hold_cnt < 20) begin
                    hold_cnt++;
                    px.out_ready = 1'b0;
                end else begin
                    px.out_ready = px.out_valid;
                end
            end
        endcase
    end

    always @(negedge clk) begin
        if (reset) begin
            if (px.in_valid && px.in_ready) begin
                exp_t e;
                e = model(int'(px.R), int'(px.G), int'(px.B));
                e.acc = cyc + 1;
                sbq.push_back(e);
            end
            if (chk_idle) begin
                checkOutput("out_valid_after_take", int'(px.out_valid), 0);
                checkOutput("in_ready_after_take", int'(px.in_ready), 1);
                chk_idle = 0;
            end
            if (px.out_valid) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL spurious_out_valid: got 1, expected 0 (cycle %0d)", cyc);
                end else begin
                    if (!seen_valid) begin
                        checkOutput("latency", cyc - sbq[0].acc, 50);
                        seen_valid = 1;
                    end
                    checkOutput("in_ready_while_valid", int'(px.in_ready), 0);
                    checkOutput("Hue", int'(px.Hue), sbq[0].h);
                    checkOutput("Saturation", int'(px.Saturation), sbq[0].s);
                    checkOutput("Value", int'(px.Value), sbq[0].v);
                    if (px.out_ready) begin
                        void'(sbq.pop_front());
                        seen_valid = 0;
                        chk_idle = 1;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input int r, input int g, input int b, output int acc);
        bit done;
        done = 0;
        acc = -1;
        @(posedge clk);
        #1;
        px.R = 8'(r);
        px.G = 8'(g);
        px.B = 8'(b);
        px.in_valid = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (px.in_ready) begin
                acc = cyc + 1;
                @(posedge clk);
                #1;
                px.in_valid = 1'b0;
                done = 1;
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("[TB] FAIL accept_timeout: got no accept, expected in_ready within 400 cycles");
            px.in_valid = 1'b0;
        end
    endtask

    task automatic waitDrain();
        bit done;
        done = 0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            if (sbq.size() == 0 && px.in_ready) done = 1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", sbq.size());
        end
    endtask

    initial begin
        int acc0, acc1, acc;
        int dir[10][3] = '{
            '{255, 0, 0}, '{0, 255, 0}, '{0, 0, 255}, '{128, 128, 128}, '{0, 0, 0},
            '{255, 0, 1}, '{255, 128, 0}, '{10, 20, 30}, '{200, 200, 0}, '{0, 200, 200}
        };

        reset = 1'b0;
        px.in_valid = 1'b0;
        px.R = 8'd0;
        px.G = 8'd0;
        px.B = 8'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_out_valid", int'(px.out_valid), 0);
        checkOutput("reset_Hue", int'(px.Hue), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_in_ready", int'(px.in_ready), 1);
        checkOutput("post_reset_Saturation", int'(px.Saturation), 0);
        checkOutput("post_reset_Value", int'(px.Value), 0);

        rdy_mode = 0;
        applyStimulus(dir[0][0], dir[0][1], dir[0][2], acc0);
        applyStimulus(dir[1][0], dir[1][1], dir[1][2], acc1);
        checkOutput("back_to_back_gap", acc1 - acc0, 52);
        for (int i = 2; i < 10; i++)
            applyStimulus(dir[i][0], dir[i][1], dir[i][2], acc);
        waitDrain();

        // Stalled result plus a pixel offered while the block is busy.
        rdy_mode = 2;
        hold_cnt = 0;
        applyStimulus(10, 20, 30, acc0);
        applyStimulus(255, 128, 0, acc1);
        checkOutput("offered_pixel_waits", (acc1 - acc0 >= 72) ? 1 : 0, 1);
        rdy_mode = 0;
        waitDrain();

        rdy_mode = 1;
        for (int i = 0; i < 25; i++) begin
            int r, g, b;
            r = $urandom_range(0, 255);
            g = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            if (i % 5 == 0) g = r;
            if (i % 7 == 0) b = g;
            applyStimulus(r, g, b, acc);
        end
        rdy_mode = 0;
        waitDrain();

        applyStimulus(255, 0, 0, acc);
        waitDrain();
        applyStimulus(50, 100, 150, acc);
        while (cyc < acc + 25) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("midreset_out_valid", int'(px.out_valid), 0);
        checkOutput("midreset_Hue", int'(px.Hue), 0);
        checkOutput("midreset_Saturation", int'(px.Saturation), 0);
        checkOutput("midreset_Value", int'(px.Value), 0);
        sbq.delete();
        seen_valid = 0;
        chk_idle = 0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midreset_in_ready", int'(px.in_ready), 1);
        applyStimulus(255, 0, 0, acc);
        waitDrain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
